// File: rtl/asphalt_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asphalt_pio_pkg
// Brief    : Register addresses and pulse-state encoding for asphalt_pio_out.
// Revision : 1.0
// ============================================================================
package asphalt_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic [0:0] {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_t;

endpackage
`default_nettype wire

// File: rtl/asphalt_pio_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : asphalt_pio_pulse_timer
// Brief    : Self-clearing pulse: holds mask_out for len_in cycles per trigger,
//            a trigger while active reloads mask and length.
// Revision : 1.0
// ============================================================================
module asphalt_pio_pulse_timer
  import asphalt_pio_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trigger,
  input  logic [WIDTH-1:0]   mask_in,
  input  logic [PULSE_W-1:0] len_in,
  output logic [WIDTH-1:0]   mask_out,
  output logic               busy
);

  pulse_state_t       state_q, state_d;
  logic [PULSE_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   mask_q,  mask_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PULSE_IDLE;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  // count holds the remaining high cycles including the current one, so the
  // pulse ends on the edge where it would step from 1 to 0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    if (trigger) begin
      state_d = PULSE_ACTIVE;
      count_d = len_in;
      mask_d  = mask_in;
    end else if (state_q == PULSE_ACTIVE) begin
      if (count_q <= PULSE_W'(1)) begin
        state_d = PULSE_IDLE;
        count_d = '0;
        mask_d  = '0;
      end else begin
        count_d = count_q - PULSE_W'(1);
      end
    end
  end

  assign mask_out = mask_q;
  assign busy     = (state_q == PULSE_ACTIVE);

endmodule
`default_nettype wire

// File: rtl/asphalt_pio_out.sv
`default_nettype none
// ============================================================================
// Module   : asphalt_pio_out
// Brief    : Avalon-MM output PIO with set/clear registers and an optional
//            timed pulse generator (enabled by ASPHALT_PIO_PULSE_EN).
// Revision : 1.0
// ============================================================================
module asphalt_pio_out
  import asphalt_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pulse_mask;
  logic             unused_in;

  assign wr        = chipselect && !write_n;
  assign wmask     = writedata[WIDTH-1:0];
  assign unused_in = ^{writedata, PULSE_W};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d = wmask;
        ADDR_OUTSET:   data_d = data_q | wmask;
        ADDR_OUTCLEAR: data_d = data_q & ~wmask;
        default:       ;
      endcase
    end
  end

`ifdef ASPHALT_PIO_PULSE_EN
  logic [PULSE_W-1:0] pulse_len_q, pulse_len_d;
  logic               trigger;
  logic               busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len_q <= '0;
    end else begin
      pulse_len_q <= pulse_len_d;
    end
  end

  always_comb begin
    pulse_len_d = pulse_len_q;
    if (wr && (address == ADDR_PULSE_LEN)) begin
      pulse_len_d = writedata[PULSE_W-1:0];
    end
  end

  // Zero mask or zero length writes are dropped here so the timer never idles
  // in ACTIVE with nothing to count.
  assign trigger = wr && (address == ADDR_PULSE) &&
                   (wmask != '0) && (pulse_len_q != '0);

  asphalt_pio_pulse_timer #(
    .WIDTH   (WIDTH),
    .PULSE_W (PULSE_W)
  ) u_pulse_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .mask_in  (wmask),
    .len_in   (pulse_len_q),
    .mask_out (pulse_mask),
    .busy     (busy)
  );
`else
  assign pulse_mask = '0;
`endif

  assign out_port = data_q | pulse_mask;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata[WIDTH-1:0]   = data_q;
`ifdef ASPHALT_PIO_PULSE_EN
      ADDR_STATUS:    readdata[0]           = busy;
      ADDR_PULSE_LEN: readdata[PULSE_W-1:0] = pulse_len_q;
      ADDR_PULSE:     readdata[WIDTH-1:0]   = pulse_mask;
`endif
      default:        ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_asphalt_pio_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_asphalt_pio_out
// Brief    : Self-checking bench for asphalt_pio_out (WIDTH=8, RESET_VALUE=1),
//            follows the ASPHALT_PIO_PULSE_EN build setting.
// Revision : 1.0
// ============================================================================
module tb_asphalt_pio_out;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] RV      = 8'h01;
  localparam int         PULSE_W = 16;
`ifdef ASPHALT_PIO_PULSE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int total = 0;
  int bad   = 0;

  asphalt_pio_out #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PULSE_W     (PULSE_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Reference model: pulse is a mask plus the absolute cycle it expires at.
  int          cyc = 0;
  logic [7:0]  m_data = RV;
  logic [15:0] m_len = '0;
  logic [7:0]  m_pm = '0;
  int          m_pend = 0;

  function automatic logic [7:0] m_pulse();
    return (EN && cyc < m_pend) ? m_pm : 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_data};
      3'd1: return (EN && cyc < m_pend) ? 32'd1 : 32'd0;
      3'd2: return EN ? {16'h0, m_len} : 32'd0;
      3'd3: return {24'h0, m_pulse()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_data = RV;
    m_len  = '0;
    m_pm   = '0;
    m_pend = cyc;
  endtask

  task automatic m_edge();
    cyc++;
    if (reset_n && chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata[7:0];
        3'd2: if (EN) m_len = writedata[15:0];
        3'd3: if (EN && writedata[7:0] != 0 && m_len != 0) begin
                m_pm   = writedata[7:0];
                m_pend = cyc + int'(m_len);
              end
        3'd4: m_data = m_data | writedata[7:0];
        3'd5: m_data = m_data & ~writedata[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one bus cycle, returns #1 after the edge with the bus idled.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] wd);
    chipselect = wr;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    m_edge();
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] d;
    logic [2:0]  ra;

    vecs[0] = '{1, 3'd0, 32'hFFFF_FFA5, 3'd0, 8'hA5, 32'hA5};
    vecs[1] = '{1, 3'd4, 32'h0000_0050, 3'd0, 8'hF5, 32'hF5};
    vecs[2] = '{1, 3'd5, 32'h0000_0081, 3'd0, 8'h74, 32'h74};
    vecs[3] = '{0, 3'd0, 32'h0000_0000, 3'd4, 8'h74, 32'h0};
    vecs[4] = '{0, 3'd0, 32'h0000_0000, 3'd5, 8'h74, 32'h0};
    vecs[5] = '{1, 3'd6, 32'hFFFF_FFFF, 3'd6, 8'h74, 32'h0};
    vecs[6] = '{1, 3'd7, 32'hFFFF_FFFF, 3'd7, 8'h74, 32'h0};
    vecs[7] = '{1, 3'd4, 32'hFFFF_FF00, 3'd0, 8'h74, 32'h74};
    vecs[8] = '{1, 3'd0, 32'h0000_0000, 3'd0, 8'h00, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {24'h0, out_port}, {24'h0, RV});
    rd(3'd0, d); chk("reset_rd0", d, 32'h1);
    rd(3'd1, d); chk("reset_rd1", d, 32'h0);
    rd(3'd2, d); chk("reset_rd2", d, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();

    // Register-map vectors
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].wr, vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      rd(vecs[i].raddr, d);
      chk($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
    end

    // Basic pulse: 4 cycles on bit1
    step(1, 3'd2, 32'd4);
    rd(3'd2, d); chk("plen_rd", d, EN ? 32'd4 : 32'd0);
    step(1, 3'd3, 32'h02);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pulse_out%0d", i), {24'h0, out_port},
          (EN && i < 4) ? 32'h02 : 32'h00);
      rd(3'd1, d);
      chk($sformatf("pulse_busy%0d", i), d, (EN && i < 4) ? 32'd1 : 32'd0);
      step(0, 3'd0, 32'h0);
    end

    // Ignored triggers
    step(1, 3'd2, 32'd0);
    step(1, 3'd3, 32'h02);
    chk("ign_len0_out", {24'h0, out_port}, 32'h0);
    rd(3'd1, d); chk("ign_len0_busy", d, 32'h0);
    step(1, 3'd2, 32'd5);
    step(1, 3'd3, 32'h00);
    chk("ign_mask0_out", {24'h0, out_port}, 32'h0);
    rd(3'd1, d); chk("ign_mask0_busy", d, 32'h0);

    // Retrigger three cycles after the first write
    step(1, 3'd2, 32'd6);
    step(1, 3'd3, 32'h01);
    chk("retrig_first", {24'h0, out_port}, EN ? 32'h01 : 32'h0);
    step(0, 3'd0, 32'h0);
    step(0, 3'd0, 32'h0);
    step(1, 3'd3, 32'h04);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("retrig_out%0d", i), {24'h0, out_port},
          (EN && i < 6) ? 32'h04 : 32'h00);
      step(0, 3'd0, 32'h0);
    end

    // Pulse on top of DATA, then asynchronous reset mid-pulse
    step(1, 3'd0, 32'h08);
    step(1, 3'd3, 32'h88);
    chk("overlay_out", {24'h0, out_port}, EN ? 32'h88 : 32'h08);
    step(0, 3'd0, 32'h0);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_out", {24'h0, out_port}, {24'h0, RV});
    rd(3'd1, d); chk("async_rst_busy", d, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 3'd0, 32'h0);
      chk($sformatf("post_rst_out%0d", i), {24'h0, out_port}, {24'h0, RV});
    end

    // Data bits shared with a pulse survive its end
    step(1, 3'd0, 32'h02);
    step(1, 3'd2, 32'd2);
    step(1, 3'd3, 32'h03);
    step(0, 3'd0, 32'h0);
    step(0, 3'd0, 32'h0);
    chk("keep_data_out", {24'h0, out_port}, 32'h02);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = $urandom_range(0, 7);
      if (a == 3'd3 && $urandom_range(0, 3) == 0) wd = 32'h0;
      step(($urandom_range(0, 2) != 0), a, wd);
      chk($sformatf("rnd%0d_out", i), {24'h0, out_port}, {24'h0, m_data | m_pulse()});
      ra = 3'($urandom_range(0, 7));
      rd(ra, d);
      chk($sformatf("rnd%0d_rd%0d", i, ra), d, m_read(ra));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
